tlul_host_port: RTL
===================

Name: tlul_host_port

Overview:
- Initiator-side TL-UL adapter that lets a simple core-style memory port (req/gnt/we/addr/wdata/be) drive TL-UL device slaves such as the data/instruction memories and peripherals.
- Converts each granted request into one A-channel beat and collects the D-channel responses in order.
- Tracks up to MaxOutstanding transactions with a source-ID counter and a small expected-ID FIFO.
- Reports every response to the core as a registered valid/data/error pulse.

Parameters:
- MaxOutstanding, 2, maximum A-beats issued but not yet answered (1..4); also the source-ID modulus.
- SrcBase, 0, value added to the local ID to form a_source (8-bit).

Ports:
- clock  input  1  clock
- reset  input  1  synchronous, active-low reset
- req_i  input  1  core request
- gnt_o  output  1  request accepted this cycle
- we_i  input  1  1 = write, 0 = read
- addr_i  input  32  byte address; bits [1:0] ignored
- be_i  input  4  write byte enables
- wdata_i  input  32  write data
- rvalid_o  output  1  response pulse, one per accepted request, in order
- rdata_o  output  32  read data; 0 for writes
- err_o  output  1  response error, qualified by rvalid_o
- tl_h_o  output  tlul_pkg::tl_h2d_t  TL-UL A channel plus d_ready
- tl_h_i  input  tlul_pkg::tl_d2h_t  TL-UL D channel plus a_ready

Behaviour:
- Reset: the interface is already decided as clock `clock` and reset `reset`, synchronous, active-low. While reset=0, on each rising edge:
  - outstanding count := 0, src counter := 0, ID FIFO emptied.
  - rvalid_o := 0, rdata_o := 0, err_o := 0.
  - tl_h_o.a_valid is forced 0.
- A channel (combinational from the inputs and state):
  - a_valid = req_i & (outstanding < MaxOutstanding).
  - a_address = {addr_i[31:2], 2'b00}; a_size = 2.
  - a_opcode = Get(4) when we_i=0; PutFullData(0) when we_i=1 and be_i==4'hF; otherwise PutPartialData(1).
  - a_mask = we_i ? be_i : 4'hF.
  - a_data = we_i ? wdata_i : 0.
  - a_source = SrcBase + src counter.
  - a_param = 0; a_user = default.
- Grant: gnt_o = a_valid & tl_h_i.a_ready.
- On a grant:
  - the src counter increments, wrapping from MaxOutstanding-1 to 0;
  - the issued a_source is pushed into the ID FIFO;
  - outstanding increments.
- A request that is not granted must be held stable by the core. The adapter adds no bubble cycles, so back-to-back grants are allowed every cycle while the limit is not reached.
- D channel:
  - d_ready = 1 constantly.
  - A D handshake is d_valid & d_ready.
- D handshake with outstanding > 0:
  - pop the ID FIFO and decrement outstanding;
  - next cycle, rvalid_o = 1 for exactly one cycle.
  - rdata_o = d_data if d_opcode == AccessAckData, else 0.
  - err_o = d_error | (d_source != popped ID) | (d_opcode not in {AccessAck, AccessAckData}).
- D handshake with outstanding == 0 (unsolicited):
  - counters are unchanged and no rvalid_o pulse is produced;
  - a sticky internal flag is set, cleared only by reset. It is visible to verification by hierarchy name `unexp_rsp_q`.
- Simultaneous grant and D handshake in the same cycle: outstanding is unchanged, and the FIFO push and pop both occur.
- At the limit (outstanding == MaxOutstanding):
  - a_valid = 0 and gnt_o = 0.
  - A D handshake in that cycle frees the slot starting the next cycle, not the same cycle.
- rvalid_o / rdata_o / err_o are registered. With no D handshake, rvalid_o returns to 0 while rdata_o holds its last value.
- Minimum latency: grant in cycle N, device responds in N+1, rvalid_o in N+2.
- Reset mid-transaction:
  - all state clears immediately;
  - D beats arriving afterwards are treated as unsolicited.

Test Plan:
- Single read: req_i=1, we_i=0, addr_i=32'h0000_0104; device a_ready=1 and returns AccessAckData, d_data=32'hDEAD_BEEF, one cycle later.
  - Expect a_opcode=4, a_address=32'h104, a_mask=4'hF, gnt_o=1.
  - Expect rvalid_o=1 two cycles after the grant, with rdata_o=32'hDEAD_BEEF and err_o=0.
- Partial write: we_i=1, be_i=4'b0011, wdata_i=32'h1234_5678, addr_i=32'h0000_0203.
  - Expect a_opcode=1, a_address=32'h200, a_mask=4'b0011, a_data=32'h1234_5678.
  - AccessAck response gives rvalid_o=1, rdata_o=0, err_o=0.
  - Repeat with be_i=4'hF and expect a_opcode=0.
- Outstanding limit: MaxOutstanding=2, req_i held high with D responses withheld.
  - Expect exactly two grants with a_source 0 then 1; gnt_o=0 on the third cycle.
  - Releasing one response gives gnt_o=1 on the following cycle.
- Simultaneous events: with outstanding=1, drive a grant and a D response in the same cycle.
  - Expect outstanding to stay 1 and the source sequence to continue 0,1,0 across wrap-around.
- Error paths:
  - A response with d_error=1 gives rvalid_o=1, err_o=1.
  - A response with d_source=5 when 0 is expected gives err_o=1.
  - A D beat with outstanding=0 gives no rvalid_o and sets unexp_rsp_q=1.
- Reset mid-operation: two requests outstanding, then drive reset=0 for one cycle.
  - Expect rvalid_o=0, a_valid=0 during reset, and outstanding=0.
  - The next request issues a_source=SrcBase+0.

Source files
------------

// File: rtl/tlul_host_port.sv
// Core req/gnt port to TL-UL host adapter: one A beat per grant, in-order D responses registered to rvalid_o.
// Grant-to-rvalid latency is 2 cycles minimum; requests stall (gnt_o=0) on a_ready=0 or at MaxOutstanding.

package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic [6:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  localparam tl_a_user_t TL_A_USER_DEFAULT = '{
    rsvd:       7'h0,
    instr_type: 4'h9,
    cmd_intg:   7'h0,
    data_intg:  7'h0
  };

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic [13:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// Generic synchronous FIFO; push is dropped when full, pop is ignored when empty.
module sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(Depth));
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= next_ptr(r_wptr);
      if (w_do_pop)  r_rptr <= next_ptr(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end
endmodule

module tlul_host_port #(
  parameter int         MaxOutstanding = 2,
  parameter logic [7:0] SrcBase        = 8'd0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output tlul_pkg::tl_h2d_t tl_h_o,
  input  tlul_pkg::tl_d2h_t tl_h_i
);
  import tlul_pkg::*;

  localparam int SW = 2;
  localparam int OW = 3;

  logic [OW-1:0] r_outstanding;
  logic [SW-1:0] r_src;
  logic          unexp_rsp_q;
  logic          r_rvalid;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_room;
  logic          w_a_valid;
  logic          w_gnt;
  logic          w_d_hs;
  logic          w_rsp;
  logic [7:0]    w_src;
  logic [7:0]    w_exp_id;
  logic          w_opcode_ok;
  logic          w_err;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic          w_unused;

  // Reset gates a_valid so nothing is issued while state is being cleared.
  assign w_room    = (r_outstanding < OW'(MaxOutstanding));
  assign w_a_valid = reset & req_i & w_room;
  assign w_gnt     = w_a_valid & tl_h_i.a_ready;
  assign w_d_hs    = tl_h_i.d_valid;
  assign w_rsp     = w_d_hs & (r_outstanding != '0);
  assign w_src     = SrcBase + {{(8-SW){1'b0}}, r_src};
  assign gnt_o     = w_gnt;

  always_comb begin
    tl_h_o           = '0;
    tl_h_o.a_valid   = w_a_valid;
    tl_h_o.a_param   = 3'h0;
    tl_h_o.a_size    = 2'd2;
    tl_h_o.a_source  = w_src;
    tl_h_o.a_address = {addr_i[31:2], 2'b00};
    tl_h_o.a_user    = TL_A_USER_DEFAULT;
    tl_h_o.d_ready   = 1'b1;
    if (!we_i) begin
      tl_h_o.a_opcode = Get;
      tl_h_o.a_mask   = 4'hF;
      tl_h_o.a_data   = 32'h0;
    end else begin
      tl_h_o.a_opcode = (be_i == 4'hF) ? PutFullData : PutPartialData;
      tl_h_o.a_mask   = be_i;
      tl_h_o.a_data   = wdata_i;
    end
  end

  sync_fifo #(
    .Width (8),
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_gnt),
    .i_data  (w_src),
    .i_pop   (w_rsp),
    .o_data  (w_exp_id),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign w_opcode_ok = (tl_h_i.d_opcode == AccessAck) | (tl_h_i.d_opcode == AccessAckData);
  assign w_err       = tl_h_i.d_error | (tl_h_i.d_source != w_exp_id) | ~w_opcode_ok;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_outstanding <= '0;
      r_src         <= '0;
      unexp_rsp_q   <= 1'b0;
    end else begin
      case ({w_gnt, w_rsp})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_gnt) r_src <= (r_src == SW'(MaxOutstanding - 1)) ? '0 : r_src + 1'b1;
      if (w_d_hs && (r_outstanding == '0)) unexp_rsp_q <= 1'b1;
    end
  end

  // rdata/err hold their last value between pulses; only rvalid returns low.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_rsp;
      if (w_rsp) begin
        r_rdata <= (tl_h_i.d_opcode == AccessAckData) ? tl_h_i.d_data : 32'h0;
        r_err   <= w_err;
      end
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;

  assign w_unused = ^{addr_i[1:0], tl_h_i.d_param, tl_h_i.d_size, tl_h_i.d_sink,
                      tl_h_i.d_user, w_fifo_empty, w_fifo_full};
endmodule
